// File: rtl/v_rx_pkg.sv
// Shared definitions for the chunked-RX interface: chunk type codes, default buffer
// geometry and the capture FSM state encoding.
package v_rx_pkg;

  localparam int unsigned RxChunkTypeNone    = 0;
  localparam int unsigned RxChunkTypeCommand = 1;
  localparam int unsigned RxChunkTypeStatus  = 2;
  localparam int unsigned RxChunkTypeBinary  = 3;
  localparam int unsigned RxChunkTypeAck     = 4;
  localparam int unsigned RxChunkTypeText    = 5;
  localparam int unsigned RxChunkTypeDebug   = 6;

  localparam int unsigned RxBufferByteSize   = 33;
  localparam int unsigned RxBufferIndexSize  = 32;
  localparam int unsigned TextQueueDepth     = 4;
  localparam int unsigned TextQueueIndexSize = 2;

  localparam int unsigned DropCountWidth     = 8;

  typedef enum logic [0:0] {
    StIdle,
    StWaitLow
  } cap_state_e;

endpackage

// File: rtl/v_text_fifo.sv
// Generic synchronous show-ahead FIFO: rdata_o always presents the head entry.
// A push while full is accepted only when a pop retires the head in the same cycle.
module v_text_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [IdxW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IdxW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (IdxW + 1)'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap modulo Depth because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + IdxW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + IdxW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (IdxW + 1)'(1);
      2'b01:   count_d = count_q - (IdxW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/v_rx_text_queue.sv
// Captures text chunks from the chunked-RX interface once per ready assertion, validates
// the length prefix, zero-masks the tail and queues accepted texts for a popping consumer.
module v_rx_text_queue
  import v_rx_pkg::*;
#(
  parameter int unsigned INTERFACE_RX_CHUNK_TYPE      = RxChunkTypeText,
  parameter int unsigned RX_CONTENT_BUFFER_BYTE_SIZE  = RxBufferByteSize,
  parameter int unsigned RX_CONTENT_BUFFER_INDEX_SIZE = RxBufferIndexSize,
  parameter int unsigned TEXT_QUEUE_DEPTH             = TextQueueDepth,
  parameter int unsigned TEXT_QUEUE_INDEX_SIZE        = TextQueueIndexSize
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [7:0]                                    rx_chunk_type,
  input  logic [RX_CONTENT_BUFFER_BYTE_SIZE*8-1:0]      rx_chunk_bytes,
  input  logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]       rx_chunk_byte_size,
  input  logic                                          rx_is_chunk_ready,
  input  logic                                          text_pop,
  input  logic                                          clear_overflow,
  output logic [(RX_CONTENT_BUFFER_BYTE_SIZE-1)*8-1:0]  text_bytes,
  output logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]       text_size,
  output logic                                          text_valid,
  output logic [TEXT_QUEUE_INDEX_SIZE:0]                text_count,
  output logic                                          text_rejected,
  output logic                                          text_overflow,
  output logic [DropCountWidth-1:0]                     text_drop_count
);

  localparam int unsigned TextBytes = RX_CONTENT_BUFFER_BYTE_SIZE - 1;
  localparam int unsigned TextW     = TextBytes * 8;
  localparam int unsigned SizeW     = RX_CONTENT_BUFFER_INDEX_SIZE;
  localparam int unsigned EntryW    = TextW + SizeW;

  localparam logic [SizeW-1:0]          MaxLen   = SizeW'(TextBytes);
  localparam logic [DropCountWidth-1:0] DropMax  = '1;

  cap_state_e state_q, state_d;
  logic       type_match;
  logic       capture;

  logic [SizeW-1:0] chunk_len;
  logic             chunk_ok;
  logic [TextW-1:0] masked_text;

  logic              push_req;
  logic              drop;
  logic [EntryW-1:0] fifo_wdata;
  logic [EntryW-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [TEXT_QUEUE_INDEX_SIZE:0] fifo_count;

  logic                      rejected_q, rejected_d;
  logic                      overflow_q, overflow_d;
  logic [DropCountWidth-1:0] drop_count_q, drop_count_d;

  assign type_match = (rx_chunk_type == 8'(INTERFACE_RX_CHUNK_TYPE));

  // Capture FSM: state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM: next state. WAIT_LOW blocks re-capture until ready drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_is_chunk_ready && type_match) begin
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!rx_is_chunk_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture FSM: outputs.
  always_comb begin
    capture = 1'b0;
    unique case (state_q)
      StIdle:    capture = rx_is_chunk_ready && type_match;
      StWaitLow: capture = 1'b0;
      default:   capture = 1'b0;
    endcase
  end

  assign chunk_len = SizeW'(rx_chunk_bytes[7:0]);
  assign chunk_ok  = (rx_chunk_byte_size != '0) &&
                     (chunk_len <= MaxLen) &&
                     (rx_chunk_byte_size >= chunk_len + SizeW'(1));

  always_comb begin
    masked_text = '0;
    for (int unsigned i = 0; i < TextBytes; i++) begin
      if (SizeW'(i) < chunk_len) begin
        masked_text[i*8 +: 8] = rx_chunk_bytes[(i+1)*8 +: 8];
      end
    end
  end

  assign push_req   = capture && chunk_ok;
  assign fifo_wdata = {chunk_len, masked_text};
  // A full queue still accepts a push when the consumer frees the head this cycle.
  assign drop       = push_req && fifo_full && !text_pop;

  v_text_fifo #(
    .Width (EntryW),
    .Depth (TEXT_QUEUE_DEPTH),
    .IdxW  (TEXT_QUEUE_INDEX_SIZE)
  ) u_text_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_req),
    .wdata_i (fifo_wdata),
    .pop_i   (text_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rejected_d   = capture && !chunk_ok;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != DropMax) begin
        drop_count_d = drop_count_q + DropCountWidth'(1);
      end
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rejected_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rejected_q   <= rejected_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Head is gated by empty so stale storage never shows, including right after reset.
  assign text_valid      = !fifo_empty;
  assign text_bytes      = fifo_empty ? '0 : fifo_rdata[TextW-1:0];
  assign text_size       = fifo_empty ? '0 : fifo_rdata[EntryW-1:TextW];
  assign text_count      = fifo_count;
  assign text_rejected   = rejected_q;
  assign text_overflow   = overflow_q;
  assign text_drop_count = drop_count_q;

endmodule

// File: tb/tb_v_rx_text_queue.sv
// Directed plus randomized bench for v_rx_text_queue, checked against a queue-based model.
module tb_v_rx_text_queue;

  localparam int BS = 33;
  localparam int IS = 32;
  localparam int D  = 4;
  localparam int QI = 2;
  localparam int TW = (BS - 1) * 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [7:0]      rx_chunk_type;
  logic [BS*8-1:0] rx_chunk_bytes;
  logic [IS-1:0]   rx_chunk_byte_size;
  logic            rx_is_chunk_ready;
  logic            text_pop;
  logic            clear_overflow;
  logic [TW-1:0]   text_bytes;
  logic [IS-1:0]   text_size;
  logic            text_valid;
  logic [QI:0]     text_count;
  logic            text_rejected;
  logic            text_overflow;
  logic [7:0]      text_drop_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [TW-1:0] mq_bytes[$];
  logic [IS-1:0] mq_size[$];
  bit            m_taken;
  bit            m_rej;
  bit            m_ovf;
  int            m_drops;

  v_rx_text_queue dut (
    .CLK                (CLK),
    .RST                (RST),
    .rx_chunk_type      (rx_chunk_type),
    .rx_chunk_bytes     (rx_chunk_bytes),
    .rx_chunk_byte_size (rx_chunk_byte_size),
    .rx_is_chunk_ready  (rx_is_chunk_ready),
    .text_pop           (text_pop),
    .clear_overflow     (clear_overflow),
    .text_bytes         (text_bytes),
    .text_size          (text_size),
    .text_valid         (text_valid),
    .text_count         (text_count),
    .text_rejected      (text_rejected),
    .text_overflow      (text_overflow),
    .text_drop_count    (text_drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq_bytes.delete();
    mq_size.delete();
    m_taken = 0;
    m_rej   = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [TW-1:0] eb;
    logic [IS-1:0] es;
    eb = '0;
    es = '0;
    if (mq_bytes.size() != 0) begin
      eb = mq_bytes[0];
      es = mq_size[0];
    end
    chk({tag, ".valid"},    TW'(text_valid),      TW'(mq_bytes.size() != 0));
    chk({tag, ".count"},    TW'(text_count),      TW'(mq_bytes.size()));
    chk({tag, ".bytes"},    text_bytes,           eb);
    chk({tag, ".size"},     TW'(text_size),       TW'(es));
    chk({tag, ".rejected"}, TW'(text_rejected),   TW'(m_rej));
    chk({tag, ".overflow"}, TW'(text_overflow),   TW'(m_ovf));
    chk({tag, ".drops"},    TW'(text_drop_count), TW'(m_drops));
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit            cap, ok, do_pop;
    int            len;
    logic [TW-1:0] txt;
    cap    = !m_taken && rx_is_chunk_ready && (rx_chunk_type == 8'd5);
    len    = int'(rx_chunk_bytes[7:0]);
    ok     = (rx_chunk_byte_size >= 1) && (len <= BS - 1) &&
             (longint'(rx_chunk_byte_size) >= longint'(len + 1));
    do_pop = text_pop && (mq_bytes.size() > 0);
    m_rej  = cap && !ok;
    if (cap && ok && mq_bytes.size() == D && !text_pop) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end else if (clear_overflow) begin
      m_ovf = 0;
    end
    if (do_pop) begin
      void'(mq_bytes.pop_front());
      void'(mq_size.pop_front());
    end
    if (cap && ok && mq_bytes.size() < D) begin
      txt = '0;
      for (int i = 0; i < len; i++) txt[i*8 +: 8] = rx_chunk_bytes[(i+1)*8 +: 8];
      mq_bytes.push_back(txt);
      mq_size.push_back(IS'(len));
    end
    if (cap) m_taken = 1;
    else if (!rx_is_chunk_ready) m_taken = 0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_chunk(input int len, input int size);
    for (int i = 0; i < BS; i++) rx_chunk_bytes[i*8 +: 8] = 8'($urandom);
    rx_chunk_bytes[7:0] = 8'(len);
    rx_chunk_byte_size  = IS'(size);
    rx_chunk_type       = 8'd5;
  endtask

  task automatic push_one(input string tag, input int len);
    set_chunk(len, len + 1);
    rx_is_chunk_ready = 1;
    step({tag, ".hi"});
    rx_is_chunk_ready = 0;
    step({tag, ".lo"});
  endtask

  task automatic sync_reset();
    RST = 1;
    #2;
    RST = 0;
    m_reset();
  endtask

  initial begin
    RST = 1;
    rx_chunk_type = '0;
    rx_chunk_bytes = '0;
    rx_chunk_byte_size = '0;
    rx_is_chunk_ready = 0;
    text_pop = 0;
    clear_overflow = 0;
    m_reset();
    #7;
    check_outputs("reset");
    @(posedge CLK);
    #1;
    RST = 0;

    // Basic text "abc" with 0xFF filler past the length
    for (int i = 0; i < BS; i++) rx_chunk_bytes[i*8 +: 8] = 8'hFF;
    rx_chunk_bytes[31:0] = 32'h6362_6103;
    rx_chunk_byte_size = 4;
    rx_chunk_type = 8'd5;
    rx_is_chunk_ready = 1;
    step("abc");
    chk("abc.low", TW'(text_bytes[23:0]), TW'(24'h636261));
    chk("abc.high", text_bytes >> 24, '0);
    chk("abc.size3", TW'(text_size), TW'(3));

    // Held ready must not duplicate
    for (int i = 0; i < 4; i++) step("hold");
    chk("hold.count1", TW'(text_count), TW'(1));
    rx_is_chunk_ready = 0;
    step("hold.lo");

    // Rejections and foreign type
    set_chunk(40, 33);
    rx_is_chunk_ready = 1;
    step("rej40");
    chk("rej40.pulse", TW'(text_rejected), TW'(1));
    rx_is_chunk_ready = 0;
    step("rej40.lo");
    set_chunk(5, 3);
    rx_is_chunk_ready = 1;
    step("rej5s3");
    rx_is_chunk_ready = 0;
    step("rej5s3.lo");
    set_chunk(2, 3);
    rx_chunk_type = 8'd7;
    rx_is_chunk_ready = 1;
    step("type7");
    rx_is_chunk_ready = 0;
    step("type7.lo");

    // Overflow: five pushes into depth four
    sync_reset();
    for (int i = 0; i < 5; i++) push_one("fill", i + 1);
    chk("fill.count4", TW'(text_count), TW'(4));
    chk("fill.ovf", TW'(text_overflow), TW'(1));
    chk("fill.drops1", TW'(text_drop_count), TW'(1));
    text_pop = 1;
    for (int i = 0; i < 4; i++) step("drain");
    text_pop = 0;
    chk("drain.empty", TW'(text_valid), TW'(0));

    // Full queue with simultaneous push and pop, then drop-vs-clear
    for (int i = 0; i < 4; i++) push_one("refill", 32 - i);
    set_chunk(7, 8);
    rx_is_chunk_ready = 1;
    text_pop = 1;
    step("fullpp");
    chk("fullpp.count4", TW'(text_count), TW'(4));
    rx_is_chunk_ready = 0;
    text_pop = 0;
    step("fullpp.lo");
    set_chunk(1, 2);
    rx_is_chunk_ready = 1;
    clear_overflow = 1;
    step("dropwins");
    rx_is_chunk_ready = 0;
    step("clear");
    chk("clear.ovf0", TW'(text_overflow), TW'(0));
    clear_overflow = 0;

    // Push and pop with a single entry
    sync_reset();
    push_one("one", 4);
    set_chunk(6, 33);
    rx_is_chunk_ready = 1;
    text_pop = 1;
    step("onepp");
    rx_is_chunk_ready = 0;
    text_pop = 0;
    step("onepp.lo");

    // Asynchronous reset with three entries stored
    sync_reset();
    for (int i = 0; i < 3; i++) push_one("pre", 10 + i);
    #2;
    RST = 1;
    #1;
    m_reset();
    check_outputs("async");
    RST = 0;
    set_chunk(0, 1);
    rx_is_chunk_ready = 1;
    step("empty_text");
    chk("empty_text.valid", TW'(text_valid), TW'(1));
    rx_is_chunk_ready = 0;
    step("empty_text.lo");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_chunk($urandom_range(0, 40), $urandom_range(0, 35));
        if ($urandom_range(0, 9) == 0) rx_chunk_byte_size = 32'hFFFF_FFF0;
        if ($urandom_range(0, 4) == 0) rx_chunk_type = 8'd7;
      end
      rx_is_chunk_ready = ($urandom_range(0, 1) == 1);
      text_pop = ($urandom_range(0, 3) == 0);
      clear_overflow = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
